// File: rtl/slc3_mem_responder.sv
// rtl/slc3_mem_responder.sv - timed memory responder for SLC-3 Mem_OE/Mem_WE strobes
//
// Serves CPU reads and writes from an on-chip word RAM with a fixed strobe-count
// latency. Address 16'hFFFF is memory-mapped I/O: reads return SW and writes
// load HEX_Data.
//
// Ports:
//   Clk            in   1   system clock, rising edge
//   Reset          in   1   synchronous, active-high reset
//   Mem_OE         in   1   read strobe, held for the access
//   Mem_WE         in   1   write strobe, held for the access
//   ADDR           in   16  word address, stable while a strobe is high
//   Data_from_CPU  in   16  write data, stable while Mem_WE is high
//   SW             in   16  switch inputs returned on a read of 16'hFFFF
//   Data_to_CPU    out  16  registered read data
//   HEX_Data       out  16  I/O register written via 16'hFFFF
//   Mem_Rdy        out  1   high in DONE (read data valid / write committed)
//   Err            out  1   one-cycle pulse on a protocol or range violation
module slc3_mem_responder #(
  parameter int ADDR_W    = 10,
  parameter int READ_LAT  = 1,
  parameter int WRITE_LAT = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Mem_OE,
  input  logic        Mem_WE,
  input  logic [15:0] ADDR,
  input  logic [15:0] Data_from_CPU,
  input  logic [15:0] SW,
  output logic [15:0] Data_to_CPU,
  output logic [15:0] HEX_Data,
  output logic        Mem_Rdy,
  output logic        Err
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  localparam int             DEPTH = 1 << ADDR_W;
  localparam logic [7:0]     RLAT  = 8'(READ_LAT);
  localparam logic [7:0]     WLAT  = 8'(WRITE_LAT);

  state_t      state, state_n;
  logic [7:0]  cnt, cnt_n;
  logic [7:0]  cnt_inc;
  logic        rd_fire, wr_fire, err_n;
  logic        in_ram, is_io;
  logic [15:0] ram [0:DEPTH-1];

  assign in_ram  = (ADDR[15:ADDR_W] == '0);
  assign is_io   = (ADDR == 16'hFFFF);
  assign cnt_inc = cnt + 8'd1;
  assign Mem_Rdy = (state == DONE);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
      cnt   <= 8'd0;
      Err   <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      Err   <= err_n;
    end
  end

  // rd_fire / wr_fire mark the edge on which the access completes; the
  // first strobe edge out of IDLE already counts as cnt=1.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    rd_fire = 1'b0;
    wr_fire = 1'b0;
    err_n   = 1'b0;
    case (state)
      IDLE: begin
        if (Mem_OE && Mem_WE) begin
          err_n = 1'b1;
        end else if (Mem_OE) begin
          cnt_n = 8'd1;
          if (RLAT == 8'd1) begin
            rd_fire = 1'b1;
            state_n = DONE;
          end else begin
            state_n = READ;
          end
        end else if (Mem_WE) begin
          cnt_n = 8'd1;
          if (WLAT == 8'd1) begin
            wr_fire = 1'b1;
            state_n = DONE;
          end else begin
            state_n = WRITE;
          end
        end
      end
      READ: begin
        if (Mem_WE || !Mem_OE) begin
          err_n   = 1'b1;
          cnt_n   = 8'd0;
          state_n = IDLE;
        end else begin
          cnt_n = cnt_inc;
          if (cnt_inc == RLAT) begin
            rd_fire = 1'b1;
            state_n = DONE;
          end
        end
      end
      WRITE: begin
        if (Mem_OE || !Mem_WE) begin
          err_n   = 1'b1;
          cnt_n   = 8'd0;
          state_n = IDLE;
        end else begin
          cnt_n = cnt_inc;
          if (cnt_inc == WLAT) begin
            wr_fire = 1'b1;
            state_n = DONE;
          end
        end
      end
      DONE: begin
        // Hold until both strobes are low so bursts never merge.
        if (!Mem_OE && !Mem_WE) begin
          cnt_n   = 8'd0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    if ((rd_fire || wr_fire) && !in_ram && !is_io) begin
      err_n = 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      Data_to_CPU <= 16'h0000;
      HEX_Data    <= 16'h0000;
    end else begin
      if (rd_fire) begin
        if (is_io)       Data_to_CPU <= SW;
        else if (in_ram) Data_to_CPU <= ram[ADDR[ADDR_W-1:0]];
        else             Data_to_CPU <= 16'h0000;
      end
      if (wr_fire && is_io) begin
        HEX_Data <= Data_from_CPU;
      end
    end
  end

  // RAM has no reset; Reset only blocks a commit on the same edge.
  always_ff @(posedge Clk) begin
    if (!Reset && wr_fire && in_ram) begin
      ram[ADDR[ADDR_W-1:0]] <= Data_from_CPU;
    end
  end

endmodule
